axi_lite_regtest_master: RTL

//  Synthesizable AXI4-Lite master that runs a register write/read-back self-test on a slave (e.g. nexys4IO).

---
 rtl/axi_lite_regtest_master.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regtest_master.sv
`timescale 1ns/1ps
// AXI4-Lite register write/read-back self-test master; 5 cycles per register with a zero-wait slave.
// Waits on slave READY/VALID per phase, aborts with timeout after TIMEOUT_CYCLES in one phase.
module axi_lite_regtest_master #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter int                              NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = 32'h44A00000,
  parameter int                              ADDR_STRIDE        = 4,
  parameter int                              TIMEOUT_CYCLES     = 1024,
  parameter bit                              STOP_ON_ERR        = 1'b0
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [1:0]                        pattern_sel,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [7:0]                        err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     fail_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_exp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_act,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = $clog2(DW);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_CHK, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      idx;
  logic [1:0]      sel_q;
  logic [DW-1:0]   seed_q;
  logic            aw_done, w_done;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [TW-1:0]   tcnt;

  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   exp_dat;
  logic            aw_hs, w_hs, ar_hs, wr_ok, phase_ok, in_phase;
  logic            tmo_hit, chk_fail, last_reg;

  function automatic logic [DW-1:0] gen_pat(input logic [1:0] sel, input logic [DW-1:0] sd,
                                            input logic [7:0] i);
    logic [DW-1:0] p;
    p = '0;
    case (sel)
      2'b01:   p[i[SW-1:0]] = 1'b1;
      2'b10:   p = ~(sd ^ DW'(i));
      default: p = sd + DW'(i);
    endcase
    return p;
  endfunction

  assign M_AXI_AWVALID = (state == S_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == S_WR) && !w_done;
  assign M_AXI_BREADY  = (state == S_WRESP);
  assign M_AXI_ARVALID = (state == S_RADDR);
  assign M_AXI_RREADY  = (state == S_RDATA);
  assign M_AXI_AWADDR  = M_AXI_AWVALID ? cur_addr : '0;
  assign M_AXI_WDATA   = M_AXI_WVALID  ? exp_dat  : '0;
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? cur_addr : '0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);

  always_comb begin
    cur_addr  = BASE_ADDR + AW'(idx) * AW'(ADDR_STRIDE);
    exp_dat   = gen_pat(sel_q, seed_q, idx);
    aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
    wr_ok     = (aw_done || aw_hs) && (w_done || w_hs);
    in_phase  = (state == S_WR) || (state == S_WRESP) || (state == S_RADDR) || (state == S_RDATA);
    phase_ok  = 1'b0;
    case (state)
      S_WR:    phase_ok = wr_ok;
      S_WRESP: phase_ok = M_AXI_BVALID;
      S_RADDR: phase_ok = ar_hs;
      S_RDATA: phase_ok = M_AXI_RVALID;
      default: phase_ok = 1'b0;
    endcase
    tmo_hit   = in_phase && !phase_ok && (tcnt == TMO_LAST);
    chk_fail  = (bresp_q != 2'b00) || (rresp_q != 2'b00) || (rdata_q != exp_dat);
    last_reg  = int'(idx) >= NUM_REGS - 1;

    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WR;
      S_WR:    if (tmo_hit) state_nxt = S_DONE; else if (wr_ok)         state_nxt = S_WRESP;
      S_WRESP: if (tmo_hit) state_nxt = S_DONE; else if (M_AXI_BVALID) state_nxt = S_RADDR;
      S_RADDR: if (tmo_hit) state_nxt = S_DONE; else if (ar_hs)        state_nxt = S_RDATA;
      S_RDATA: if (tmo_hit) state_nxt = S_DONE; else if (M_AXI_RVALID) state_nxt = S_CHK;
      S_CHK:   state_nxt = (last_reg || (chk_fail && STOP_ON_ERR)) ? S_DONE : S_WR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      sel_q     <= '0;
      seed_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      tcnt      <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  tcnt <= '0;
      else if (tcnt != TMO_LAST) tcnt <= tcnt + TW'(1);

      // Each beat is tracked on its own so AW and W may complete in either order.
      if (state == S_WR && !(wr_ok || tmo_hit)) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      if (tmo_hit) begin
        timeout   <= 1'b1;
        fail_addr <= cur_addr;
      end
      if (state != S_DONE && state_nxt == S_DONE)
        pass <= !tmo_hit && (err_count == 8'd0) && !(state == S_CHK && chk_fail);

      case (state)
        S_IDLE, S_DONE: if (start) begin
          idx       <= '0;
          seed_q    <= seed;
          sel_q     <= pattern_sel;
          err_count <= '0;
          fail_addr <= '0;
          fail_exp  <= '0;
          fail_act  <= '0;
          pass      <= 1'b0;
          timeout   <= 1'b0;
        end
        S_WRESP: if (M_AXI_BVALID) bresp_q <= M_AXI_BRESP;
        S_RDATA: if (M_AXI_RVALID) begin
          rdata_q <= M_AXI_RDATA;
          rresp_q <= M_AXI_RRESP;
        end
        S_CHK: begin
          if (chk_fail) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0) begin
              fail_addr <= cur_addr;
              fail_exp  <= exp_dat;
              fail_act  <= rdata_q;
            end
          end
          if (state_nxt == S_WR) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
